// File: rtl/multisim_pkg.sv
// multisim_pkg
//   Shared constants and helpers for the multisim pull-side blocks.
//   - MULTISIM_DESER_MAX_RATIO : largest supported words-per-beat ratio
//   - deser_cnt_w(ratio)       : width of the word counter for a given ratio
package multisim_pkg;

  localparam int MULTISIM_DESER_MAX_RATIO = 16;

  // The counter only ever holds 0..ratio-1, so clog2(ratio) bits suffice.
  // The floor of 1 keeps degenerate ratios from producing a zero-width vector.
  function automatic int deser_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/multisim_deser_out_stage.sv
// multisim_deser_out_stage
//   Single-entry output register for the deserializer.  Holds one packed beat
//   and presents it on a vld/rdy interface.  The beat stays stable while the
//   consumer stalls.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data this edge (caller guarantees slot_free)
//   load_data  : beat to capture
//   out_rdy    : consumer ready
//   slot_free  : register empty or being drained this edge
//   out_vld    : beat valid
//   out_data   : beat contents
module multisim_deser_out_stage
  import multisim_pkg::*;
#(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_rdy,
  output logic              slot_free,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A load always wins over a drain.  When both happen on the same edge, the
  // outgoing beat transfers and the new beat takes its place with no bubble.
  always_comb begin
    slot_free = !vld_q || out_rdy;
    vld_d     = vld_q;
    data_d    = data_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = load_data;
    end else if (vld_q && out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_data = data_q;

endmodule

// File: rtl/multisim_pull_deserializer.sv
// multisim_pull_deserializer
//   Packs RATIO consecutive IN_WIDTH words from the pull client into one
//   IN_WIDTH*RATIO beat.  Word 0 lands in the least significant bits.
//   Optional feature macro: MULTISIM_DESER_LAST_EN.  When it is defined, in_last
//   closes a beat early, and out_keep marks the words that are filled.
// Ports
//   clk, rst  : clock, synchronous active-high reset
//   in_vld    : word valid (client data_vld)
//   in_data   : word (client data)
//   in_rdy    : word accepted on in_vld && in_rdy (client data_rdy)
//   out_vld   : packed beat valid
//   out_data  : packed beat
//   out_rdy   : consumer ready
//   in_last   : [LAST_EN] accepted word closes the current beat
//   out_keep  : [LAST_EN] bit i set when word i of the beat is valid
module multisim_pull_deserializer
  import multisim_pkg::*;
#(
  parameter int IN_WIDTH = 64,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vld,
  input  logic [IN_WIDTH-1:0]       in_data,
  output logic                      in_rdy,
  output logic                      out_vld,
  output logic [IN_WIDTH*RATIO-1:0] out_data,
  input  logic                      out_rdy
`ifdef MULTISIM_DESER_LAST_EN
  ,
  input  logic                      in_last,
  output logic [RATIO-1:0]          out_keep
`endif
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = deser_cnt_w(RATIO);
  localparam int ACC_WORDS = RATIO - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
`ifdef MULTISIM_DESER_LAST_EN
  localparam int STAGE_W = OUT_WIDTH + RATIO;
`else
  localparam int STAGE_W = OUT_WIDTH;
`endif

  // The closing word goes straight into the output beat.  As a result, acc only
  // ever needs to hold the first RATIO-1 words.
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ACC_WORDS*IN_WIDTH-1:0] acc_q, acc_d;

  logic                 slot_free;
  logic                 cnt_not_last;
  logic                 accept;
  logic                 closing;
  logic [OUT_WIDTH-1:0] beat;
  logic [RATIO-1:0]     keep;
  logic [STAGE_W-1:0]   stage_in;
  logic [STAGE_W-1:0]   stage_out;

  // Ready/close decision.  A word that will close a beat needs the output
  // slot.  A word that only fills acc can be taken even while the consumer
  // stalls.  cnt never exceeds RATIO-1, so "!= RATIO-1" is the same test as
  // "< RATIO-1".
  always_comb begin
    cnt_not_last = (cnt_q != CNT_LAST);
`ifdef MULTISIM_DESER_LAST_EN
    in_rdy  = (cnt_not_last && !in_last) || slot_free;
    accept  = in_vld && in_rdy;
    closing = accept && (!cnt_not_last || in_last);
`else
    in_rdy  = cnt_not_last || slot_free;
    accept  = in_vld && in_rdy;
    closing = accept && !cnt_not_last;
`endif
  end

  // Beat assembly.  acc is cleared after every close, so words at or above
  // cnt are already zero.  The incoming word is then dropped into slot cnt,
  // which also gives zero-filled upper words for an early close.
  always_comb begin
    beat = OUT_WIDTH'(acc_q);
    keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        beat[i*IN_WIDTH +: IN_WIDTH] = in_data;
      end
      keep[i] = (CNT_W'(i) <= cnt_q);
    end
  end

  // Accumulator and word counter update.  Only an accepted word can change
  // them.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (closing) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      for (int i = 0; i < ACC_WORDS; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          acc_d[i*IN_WIDTH +: IN_WIDTH] = in_data;
        end
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

`ifdef MULTISIM_DESER_LAST_EN
  assign stage_in = {keep, beat};
  assign out_data = stage_out[OUT_WIDTH-1:0];
  assign out_keep = stage_out[STAGE_W-1:OUT_WIDTH];
`else
  assign stage_in = beat;
  assign out_data = stage_out;
  // keep is meaningful only with in_last support.  Folding it in here keeps
  // it referenced in both builds.
  logic unused_keep;
  assign unused_keep = ^keep;
`endif

  multisim_deser_out_stage #(
    .DATA_W (STAGE_W)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .load      (closing),
    .load_data (stage_in),
    .out_rdy   (out_rdy),
    .slot_free (slot_free),
    .out_vld   (out_vld),
    .out_data  (stage_out)
  );

endmodule

// File: tb/tb_multisim_pull_deserializer.sv
// tb_multisim_pull_deserializer
//   Self-checking bench for multisim_pull_deserializer (IN_WIDTH=64, RATIO=4).
//   A negedge monitor keeps a word/beat reference model built from queues.
//   Directed sequences and randomized traffic drive the DUT against that model.
//   Define MULTISIM_DESER_LAST_EN to also exercise in_last/out_keep.
module tb_multisim_pull_deserializer;

  localparam int IN_W  = 64;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;
`ifdef MULTISIM_DESER_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [RATIO-1:0] keep;
  } beat_t;

  logic             clk;
  logic             rst;
  logic             in_vld;
  logic [IN_W-1:0]  in_data;
  logic             in_rdy;
  logic             out_vld;
  logic [OUT_W-1:0] out_data;
  logic             out_rdy;
  logic             in_last;
`ifdef MULTISIM_DESER_LAST_EN
  logic [RATIO-1:0] out_keep;
`endif

  int errors;
  int checks;
  int beats_out;
  bit mon_on;

  // Reference model state: words collected toward the next beat, and beats
  // produced but not yet taken by the consumer.
  logic [IN_W-1:0] part_q[$];
  beat_t           exp_q[$];
  logic            exp_vld, exp_rdy, last_now, hold_pending;
  logic [OUT_W-1:0] held_data;
  beat_t           nb;

  multisim_pull_deserializer #(
    .IN_WIDTH (IN_W),
    .RATIO    (RATIO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_rdy  (out_rdy)
`ifdef MULTISIM_DESER_LAST_EN
    ,
    .in_last  (in_last),
    .out_keep (out_keep)
`endif
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [OUT_W-1:0] observed,
                             input logic [OUT_W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then move to just after the next rising edge.
  task automatic applyStimulus(input logic vld, input logic [IN_W-1:0] data,
                               input logic last, input logic ordy);
    in_vld  = vld;
    in_data = data;
    in_last = last;
    out_rdy = ordy;
    @(posedge clk);
    #1;
  endtask

  // Hold a word on the input until it is accepted, giving up after a bound.
  task automatic sendWord(input logic [IN_W-1:0] data, input logic last);
    logic got;
    got     = 1'b0;
    in_vld  = 1'b1;
    in_data = data;
    in_last = last;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = in_rdy;
      @(posedge clk);
      #1;
    end
    checkOutput("send_accept", got, 1'b1);
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  // Monitor and reference model.  At each falling edge, compare the DUT
  // with the model.  Then advance the model by what the next rising edge will do.
  always @(negedge clk) begin
    if (mon_on) begin
      exp_vld  = (exp_q.size() != 0);
      last_now = LastEn && in_last;
      exp_rdy  = ((part_q.size() < RATIO - 1) && !last_now) || !exp_vld || out_rdy;
      checkOutput("out_vld", out_vld, exp_vld);
      checkOutput("in_rdy", in_rdy, exp_rdy);
      if (exp_vld) begin
        checkOutput("out_data", out_data, exp_q[0].data);
`ifdef MULTISIM_DESER_LAST_EN
        checkOutput("out_keep", out_keep, exp_q[0].keep);
`endif
      end
      if (hold_pending) begin
        checkOutput("hold_data", out_data, held_data);
      end
      if (rst) begin
        part_q.delete();
        exp_q.delete();
      end else begin
        if (exp_vld && out_rdy) begin
          void'(exp_q.pop_front());
          beats_out++;
        end
        if (in_vld && exp_rdy) begin
          part_q.push_back(in_data);
          if (part_q.size() == RATIO || last_now) begin
            nb.data = '0;
            nb.keep = '0;
            for (int i = 0; i < part_q.size(); i++) begin
              nb.data[i*IN_W +: IN_W] = part_q[i];
              nb.keep[i] = 1'b1;
            end
            exp_q.push_back(nb);
            part_q.delete();
          end
        end
      end
      hold_pending = exp_vld && !out_rdy && !rst;
      held_data    = out_data;
    end
  end

  // Global watchdog so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    int sent;
    int cycles;
    int beats_start;
    logic got;
    logic [IN_W-1:0] word_a, word_b;

    errors = 0; checks = 0; beats_out = 0; mon_on = 1'b0;
    hold_pending = 1'b0; held_data = '0;
    rst = 1'b1; in_vld = 1'b0; in_data = '0; in_last = 1'b0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_on = 1'b1;
    $display("[TB] reset released");

    // Reset state.
    checkOutput("reset_out_vld", out_vld, 1'b0);
    checkOutput("reset_out_data", out_data, '0);
    checkOutput("reset_in_rdy", in_rdy, 1'b1);

    // Test 1: four words back to back with the consumer ready.
    out_rdy = 1'b1;
    for (int w = 1; w <= 3; w++) sendWord(IN_W'(w), 1'b0);
    checkOutput("t1_vld_before_close", out_vld, 1'b0);
    sendWord(IN_W'(4), 1'b0);
    checkOutput("t1_vld", out_vld, 1'b1);
    checkOutput("t1_data", out_data, {64'd4, 64'd3, 64'd2, 64'd1});
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t1_vld_drop", out_vld, 1'b0);

    // Test 2: consumer stalled, input fills until the closing word blocks.
    out_rdy = 1'b0;
    for (int w = 1; w <= 7; w++) sendWord(IN_W'(w), 1'b0);
    checkOutput("t2_in_rdy_full", in_rdy, 1'b0);
    in_vld  = 1'b1;
    in_data = IN_W'(8);
    @(posedge clk);
    #1;
    checkOutput("t2_stall_vld", out_vld, 1'b1);
    checkOutput("t2_stall_data", out_data, {64'd4, 64'd3, 64'd2, 64'd1});
    checkOutput("t2_stall_in_rdy", in_rdy, 1'b0);
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    checkOutput("t2_swap_vld", out_vld, 1'b1);
    checkOutput("t2_swap_data", out_data, {64'd8, 64'd7, 64'd6, 64'd5});
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t2_drain_vld", out_vld, 1'b0);

    // Test 3: 400 words with random gaps, consumer always ready.
    beats_start = beats_out;
    sent = 0;
    cycles = 0;
    out_rdy = 1'b1;
    in_last = 1'b0;
    while (sent < 400 && cycles < 4000) begin
      in_vld  = ($urandom_range(0, 3) != 0);
      in_data = {$urandom(), $urandom()};
      @(negedge clk);
      got = in_vld && in_rdy;
      @(posedge clk);
      #1;
      if (got) sent++;
      cycles++;
    end
    in_vld = 1'b0;
    repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t3_words_sent", 32'(sent), 32'd400);
    checkOutput("t3_beats", 32'(beats_out - beats_start), 32'd100);
    checkOutput("t3_model_empty", 32'(exp_q.size() + part_q.size()), 32'd0);

    // Test 4: reset in the middle of a partial beat.
    sendWord(IN_W'(11), 1'b0);
    sendWord(IN_W'(12), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t4_vld_after_rst", out_vld, 1'b0);
    for (int w = 21; w <= 23; w++) sendWord(IN_W'(w), 1'b0);
    checkOutput("t4_vld_partial", out_vld, 1'b0);
    sendWord(IN_W'(24), 1'b0);
    checkOutput("t4_data", out_data, {64'd24, 64'd23, 64'd22, 64'd21});

`ifdef MULTISIM_DESER_LAST_EN
    // Test 5: early close with in_last on the second word.
    word_a = {$urandom(), $urandom()};
    word_b = {$urandom(), $urandom()};
    sendWord(word_a, 1'b0);
    sendWord(word_b, 1'b1);
    checkOutput("t5_vld", out_vld, 1'b1);
    checkOutput("t5_data", out_data, {128'd0, word_b, word_a});
    checkOutput("t5_keep", out_keep, 4'b0011);
`else
    word_a = '0;
    word_b = '0;
`endif
    applyStimulus(1'b0, word_a ^ word_b, 1'b0, 1'b1);

    // Test 6: random traffic with a randomly stalling consumer.
    for (int c = 0; c < 600; c++) begin
      applyStimulus(($urandom_range(0, 2) != 0), {$urandom(), $urandom()},
                    LastEn && ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1);
    end
    in_vld = 1'b0;
    repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t6_out_drained", out_vld, exp_q.size() != 0);
    checkOutput("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
